// File: rtl/fetch_queue.sv
// Decoupling FIFO between the fetch stage and the decode pipeline register.
// Holds {PC, PC+4, instruction, predictor tags} per entry and drops everything on flush.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid_F,
    output logic                       push_ready_F,
    input  logic [WIDTH-1:0]           PC_F,
    input  logic [WIDTH-1:0]           normal_F,
    input  logic [WIDTH-1:0]           inst_F,
    input  logic                       BP_decision_F,
    input  logic                       BP_en_F,
    output logic                       pop_valid_DE,
    input  logic                       pop_ready_DE,
    output logic [WIDTH-1:0]           PC_DE,
    output logic [WIDTH-1:0]           normal_DE,
    output logic [WIDTH-1:0]           inst_DE,
    output logic                       BP_decision_DE,
    output logic                       BP_en_DE,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] pc_mem_q     [DEPTH];
    logic [WIDTH-1:0] normal_mem_q [DEPTH];
    logic [WIDTH-1:0] inst_mem_q   [DEPTH];
    logic             bp_dec_mem_q [DEPTH];
    logic             bp_en_mem_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_s, empty_s, push_s, pop_s;

    // Occupancy flags and handshake qualification; flush suppresses both moves.
    always_comb begin
        full_s  = (count_q == CW'(DEPTH));
        empty_s = (count_q == {CW{1'b0}});
        push_s  = push_valid_F && !full_s && !flush;
        pop_s   = pop_ready_DE && !empty_s && !flush;
    end

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry storage: cleared only by reset, flush leaves stale data behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]     <= {WIDTH{1'b0}};
                normal_mem_q[i] <= {WIDTH{1'b0}};
                inst_mem_q[i]   <= {WIDTH{1'b0}};
                bp_dec_mem_q[i] <= 1'b0;
                bp_en_mem_q[i]  <= 1'b0;
            end
        end else if (push_s) begin
            pc_mem_q[wr_ptr_q]     <= PC_F;
            normal_mem_q[wr_ptr_q] <= normal_F;
            inst_mem_q[wr_ptr_q]   <= inst_F;
            bp_dec_mem_q[wr_ptr_q] <= BP_decision_F;
            bp_en_mem_q[wr_ptr_q]  <= BP_en_F;
        end else begin
            pc_mem_q[wr_ptr_q] <= pc_mem_q[wr_ptr_q];
        end
    end

    // Head presentation: zeroed whenever the queue holds nothing.
    always_comb begin
        if (empty_s) begin
            PC_DE          = {WIDTH{1'b0}};
            normal_DE      = {WIDTH{1'b0}};
            inst_DE        = {WIDTH{1'b0}};
            BP_decision_DE = 1'b0;
            BP_en_DE       = 1'b0;
        end else begin
            PC_DE          = pc_mem_q[rd_ptr_q];
            normal_DE      = normal_mem_q[rd_ptr_q];
            inst_DE        = inst_mem_q[rd_ptr_q];
            BP_decision_DE = bp_dec_mem_q[rd_ptr_q];
            BP_en_DE       = bp_en_mem_q[rd_ptr_q];
        end
    end

    // Status outputs decoded from registered occupancy only.
    always_comb begin
        count        = count_q;
        full         = full_s;
        empty        = empty_s;
        push_ready_F = !full_s;
        pop_valid_DE = !empty_s;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, flush, push_valid_F, pop_ready_DE;
    logic        BP_decision_F, BP_en_F;
    logic [31:0] PC_F, normal_F, inst_F;
    logic        push_ready_F, pop_valid_DE, BP_decision_DE, BP_en_DE, full, empty;
    logic [31:0] PC_DE, normal_DE, inst_DE;
    logic [2:0]  count;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] fill_inst [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

    fetch_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid_F(push_valid_F), .push_ready_F(push_ready_F),
        .PC_F(PC_F), .normal_F(normal_F), .inst_F(inst_F),
        .BP_decision_F(BP_decision_F), .BP_en_F(BP_en_F),
        .pop_valid_DE(pop_valid_DE), .pop_ready_DE(pop_ready_DE),
        .PC_DE(PC_DE), .normal_DE(normal_DE), .inst_DE(inst_DE),
        .BP_decision_DE(BP_decision_DE), .BP_en_DE(BP_en_DE),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                           input logic bd, input logic be);
        push_valid_F  = v;
        PC_F          = pc;
        normal_F      = pc + 32'd4;
        inst_F        = ins;
        BP_decision_F = bd;
        BP_en_F       = be;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pop_ready_DE = 1'b0;
        set_pkt(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_push_ready", 32'(push_ready_F), 32'd1);
        check_val("rst_pop_valid", 32'(pop_valid_DE), 32'd0);
        check_val("rst_inst", inst_DE, 32'd0);

        // fill without popping
        for (int i = 0; i < 4; i++) begin
            set_pkt(1'b1, 32'(4 * i), fill_inst[i], 1'b0, 1'b0);
            step();
            check_val("fill_count", 32'(count), 32'(i + 1));
            check_val("fill_pop_valid", 32'(pop_valid_DE), 32'd1);
        end
        check_val("fill_full", 32'(full), 32'd1);
        check_val("fill_push_ready", 32'(push_ready_F), 32'd0);
        set_pkt(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step();
        check_val("refused_count", 32'(count), 32'd4);
        check_val("head_inst", inst_DE, 32'h0000_0013);
        check_val("head_pc", PC_DE, 32'h0);
        check_val("head_normal", normal_DE, 32'h4);

        // drain in order
        set_pkt(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        pop_ready_DE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("drain_pc", PC_DE, 32'(4 * i));
            check_val("drain_inst", inst_DE, fill_inst[i]);
            step();
        end
        check_val("drain_empty", 32'(empty), 32'd1);
        check_val("drain_pop_valid", 32'(pop_valid_DE), 32'd0);
        check_val("drain_pc_zero", PC_DE, 32'd0);
        check_val("drain_inst_zero", inst_DE, 32'd0);
        step();
        check_val("pop_empty_count", 32'(count), 32'd0);

        // preload two, then sustained push+pop with pointer wrap
        pop_ready_DE = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_pkt(1'b1, 32'h10 + 32'(4 * k), 32'(k), 1'b0, 1'b0);
            step();
        end
        check_val("pre_count", 32'(count), 32'd2);
        pop_ready_DE = 1'b1;
        for (int k = 2; k < 12; k++) begin
            set_pkt(1'b1, 32'h10 + 32'(4 * k), 32'(k), 1'b0, 1'b0);
            check_val("stream_pc", PC_DE, 32'h10 + 32'(4 * (k - 2)));
            step();
            check_val("stream_count", 32'(count), 32'd2);
        end
        check_val("stream_head", PC_DE, 32'h38);

        // bring to count=3 then flush with a push in the same cycle
        pop_ready_DE = 1'b0;
        set_pkt(1'b1, 32'h100, 32'h100, 1'b0, 1'b0);
        step();
        check_val("preflush_count", 32'(count), 32'd3);
        flush = 1'b1;
        set_pkt(1'b1, 32'h200, 32'h200, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        check_val("flush_count", 32'(count), 32'd0);
        check_val("flush_pop_valid", 32'(pop_valid_DE), 32'd0);
        check_val("flush_pc", PC_DE, 32'd0);
        set_pkt(1'b1, 32'h40, 32'h0000_0013, 1'b0, 1'b1);
        step();
        set_pkt(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("redirect_count", 32'(count), 32'd1);
        check_val("redirect_pc", PC_DE, 32'h40);
        check_val("redirect_normal", normal_DE, 32'h44);
        check_val("redirect_bp_dec", 32'(BP_decision_DE), 32'd0);
        check_val("redirect_bp_en", 32'(BP_en_DE), 32'd1);
        pop_ready_DE = 1'b1;
        step();
        check_val("redirect_alone", 32'(empty), 32'd1);

        // full plus simultaneous pop: push refused, accepted next cycle
        pop_ready_DE = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_pkt(1'b1, 32'h50 + 32'(4 * k), 32'(k), 1'b0, 1'b0);
            step();
        end
        check_val("full2_count", 32'(count), 32'd4);
        pop_ready_DE = 1'b1;
        set_pkt(1'b1, 32'h60, 32'h60, 1'b1, 1'b0);
        step();
        check_val("fullpop_count", 32'(count), 32'd3);
        check_val("fullpop_head", PC_DE, 32'h54);
        step();
        check_val("nextpush_count", 32'(count), 32'd3);
        check_val("nextpush_head", PC_DE, 32'h58);
        set_pkt(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("tail_pc0", PC_DE, 32'h58);
        step();
        check_val("tail_pc1", PC_DE, 32'h5C);
        step();
        check_val("tail_pc2", PC_DE, 32'h60);
        check_val("tail_bp_dec", 32'(BP_decision_DE), 32'd1);
        step();
        check_val("tail_empty", 32'(empty), 32'd1);

        // reset and flush together mid-operation
        pop_ready_DE = 1'b0;
        set_pkt(1'b1, 32'h70, 32'h70, 1'b0, 1'b0);
        step();
        step();
        check_val("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        set_pkt(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_val("midrst_count", 32'(count), 32'd0);
        check_val("midrst_ready", 32'(push_ready_F), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between the fetch stage (PC register, instruction memory, branch predictor) and the decode pipeline register. Each accepted fetch packet carries the instruction, its PC, its PC+4 value, and the branch-predictor tags for that instruction. Packets are held in a circular FIFO and presented in order to decode, so fetch can run ahead while decode stalls. A misprediction flush from the hazard unit discards every held packet in one cycle.

## Interface

Parameters:
- WIDTH, 32, data and address width.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous and active-high.
- flush  input  1  discard all entries (driven by branch correction / flush_DE).
- push_valid_F  input  1  fetch presents a packet.
- push_ready_F  output  1  queue can accept; equals !full.
- PC_F  input  WIDTH  PC of the fetched instruction.
- normal_F  input  WIDTH  PC_F+4.
- inst_F  input  WIDTH  instruction word.
- BP_decision_F  input  1  predicted taken.
- BP_en_F  input  1  instruction is a conditional branch.
- pop_valid_DE  output  1  head entry is valid; equals !empty.
- pop_ready_DE  input  1  decode consumes head this cycle (low when stall_DE).
- PC_DE, normal_DE, inst_DE  output  WIDTH  head entry fields.
- BP_decision_DE, BP_en_DE  output  1  head entry predictor tags.
- count  output  $clog2(DEPTH+1)  current occupancy.
- full, empty  output  1  occupancy flags.

## Operation

- Storage: DEPTH entries of {PC, normal, inst, BP_decision, BP_en}; write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy register count 0..DEPTH.
- push = push_valid_F && !full. On push: the entry at wr_ptr is written, wr_ptr increments.
- pop = pop_ready_DE && !empty. On pop: rd_ptr increments.
- count_next = count + push − pop. With push and pop in the same cycle, count is unchanged.
- push_ready_F depends only on full, never on pop_ready_DE. When full, a push is refused even if a pop happens in the same cycle.
- Pop when empty: no effect. Push when full: no effect, and the packet is not stored; fetch must hold the PC (stall_F = !push_ready_F).
- Head outputs drive the storage at rd_ptr combinationally. When empty, all head data outputs are forced to 0 and pop_valid_DE is 0.
- flush = 1: on the next edge wr_ptr, rd_ptr and count all become 0. Flush has priority over push and pop in the same cycle, and any packet presented that cycle is dropped.
- Flush does not clear storage contents. Outputs still read 0 because the queue is empty.
- rst = 1: same as flush, and additionally every storage entry is cleared to 0.
- rst and flush asserted together: rst behaviour applies.
- full = (count == DEPTH); empty = (count == 0).

## Timing

- Reset values: count 0, full 0, empty 1, push_ready_F 1, pop_valid_DE 0, all head data outputs 0.
- Latency: a packet pushed at edge N appears at the decode-side outputs after edge N. When the queue was empty, pop_valid_DE rises in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained, provided count < DEPTH.
- Flush asserted in cycle N: pop_valid_DE = 0 from cycle N+1. A push from the redirected PC in cycle N+1 is accepted.
- Reset mid-operation: the queue is empty in the cycle after the rst edge, regardless of prior state.
- Flags and count are registered state plus combinational decode of count. No output depends combinationally on push_valid_F.

## Test plan

- Reset: assert rst 2 cycles, release -> count=0, empty=1, push_ready_F=1, pop_valid_DE=0, inst_DE=0.
- Fill with pop_ready_DE=0: push inst 0x00000013, 0x00100093, 0x00200113, 0x00300193 at PCs 0x0,0x4,0x8,0xC -> count 1..4; full=1 after the 4th; a 5th push is refused and count stays 4; inst_DE=0x00000013, PC_DE=0x0, normal_DE=0x4.
- Drain in order: from full, pop_ready_DE=1 for 4 cycles -> PC_DE sequence 0x0,0x4,0x8,0xC, then empty=1 and outputs 0.
- Simultaneous push/pop with count=2 over 10 cycles -> count stays 2; pointers wrap past DEPTH−1; PC order is preserved, with each push at PC 0x10+4k popped 2 cycles later.
- Flush with count=3, push_valid_F=1, BP_decision_F=1 in the same cycle -> next cycle count=0, pop_valid_DE=0; the flush-cycle packet is not stored; the following push at PC 0x40 appears alone at head one cycle later.
- Full plus simultaneous pop: count=4, pop_ready_DE=1, push_valid_F=1 -> push refused and count=3; next cycle push accepted and count=3.
